imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time writer for the processor's instruction memory.
- Accepts a framed byte stream over a valid/ready handshake: a length byte, then N instruction bytes, then a checksum byte.
- Writes each instruction byte to consecutive instruction-memory addresses starting at 0.
- Holds the processor core in reset until a frame loads with a correct checksum; the core then fetches from PC=0.

Parameters:
- ADDR_W, 8, width of instruction-memory address bus.
- MAX_WORDS, 32, instruction-memory depth; frame lengths above this are rejected.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a load; ignored while busy=1.
- in_valid  input  1  upstream byte valid.
- in_data  input  8  upstream byte.
- in_ready  output  1  loader can accept in_data this cycle.
- imem_we  output  1  instruction-memory write strobe.
- imem_addr  output  ADDR_W  instruction-memory write address.
- imem_wdata  output  8  instruction-memory write data.
- core_reset  output  1  reset to processor core, active-high.
- busy  output  1  a frame is in progress.
- done  output  1  last load succeeded (sticky).
- error  output  1  last load failed (sticky).
- words_loaded  output  8  count of instruction bytes written in the current/last frame.

Behaviour:
- Reset, asynchronous: state=IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_reset=1, busy=0, done=0, error=0, words_loaded=0. Internal length, index and checksum registers clear to 0.
- Transfer rule: a byte is accepted on a rising edge where in_valid&&in_ready. in_ready is high only in LEN, DATA and CSUM, and is driven from state, not from in_valid.
- State IDLE:
  - in_ready=0, busy=0.
  - start=1 -> LEN; set core_reset=1, clear done, error, words_loaded, index and checksum.
- State LEN:
  - On accept: checksum=in_data; length=in_data.
  - length==0 or length>MAX_WORDS -> ERROR.
  - Otherwise -> DATA.
- State DATA, on each accept:
  - checksum+=in_data (mod 256).
  - Registered write, one-cycle latency: next cycle imem_we=1, imem_addr=index, imem_wdata=in_data.
  - index++, words_loaded++.
  - When index reaches length -> CSUM.
  - imem_we is high for exactly one cycle per accepted byte and never outside DATA writes.
- State CSUM:
  - On accept: (checksum+in_data) mod 256==0 -> DONE, else -> ERROR.
- State DONE:
  - done=1, core_reset=0, busy=0, in_ready=0.
  - start -> LEN, reasserting core_reset in the same cycle start is sampled.
- State ERROR:
  - error=1, core_reset stays 1, busy=0, in_ready=0.
  - start -> LEN with the same restart behaviour as DONE.
- busy=1 in LEN, DATA and CSUM.
- Stalls: in_valid low for any number of cycles in LEN, DATA or CSUM holds state; there is no timeout.
- start during LEN, DATA or CSUM is ignored.
- Memory contents after a failed frame are undefined; the core never runs them.
- Addresses 0..length-1 are written in order with no wrap. imem_addr is zero-extended from the 8-bit index to ADDR_W.
- Reset mid-frame returns to reset values immediately. No further imem_we is issued, including a write pending from the last accepted byte.
- Registered outputs: in_ready, core_reset, busy, done, error, imem_*.

Test Plan:
- Good frame: reset, start, stream 0x03,0x10,0x2A,0x45,0x7E -> writes addr0=0x10, addr1=0x2A, addr2=0x45, each as a single imem_we pulse. Then done=1, error=0, core_reset=0, words_loaded=3.
- Bad checksum: same frame with checksum 0x7F -> error=1, done=0, core_reset=1, three writes still observed.
- Length checks: length 0x00 -> ERROR right after the LEN accept with no imem_we. Length MAX_WORDS+1=0x21 -> ERROR. Length 0x20 with a correct checksum -> DONE with last write at addr 0x1F.
- Handshake stalls: good frame with in_valid deasserted 1-3 random cycles between bytes; start pulsed mid-frame -> identical writes and result to an unstalled run, start ignored.
- Reset mid-DATA: reset asserted the cycle after the 2nd data byte is accepted -> no imem_we afterwards, all outputs at reset values. A fresh start plus good frame then succeeds.
- Reload: after DONE, start -> core_reset=1 within one cycle. A second good frame 0x01,0xA5,0x5A -> addr0=0xA5, DONE, core_reset=0.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: boot-time loader for the instruction memory.
// Receives a framed byte stream (length, N instruction bytes, checksum),
// writes the instruction bytes to addresses 0..N-1 and keeps the processor
// core in reset until a frame with a correct checksum has been loaded.
//
// Handshake: a byte moves on a rising clk edge where in_valid && in_ready.
// in_ready is a registered function of the FSM state only (high in LEN,
// DATA and CSUM); it never depends on in_valid. Upstream may hold in_valid
// low for any number of cycles; the loader simply waits, with no timeout.
module imem_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [7:0]        imem_wdata,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [7:0]        words_loaded,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_CSUM  = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  // Largest legal frame length, widened so a length byte can be compared
  // without truncating the limit.
  localparam logic [8:0] MAX_LEN = 9'(MAX_WORDS);

  state_t            r_state;
  state_t            w_next_state;

  logic              r_in_ready;
  logic              r_imem_we;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [7:0]        r_imem_wdata;
  logic              r_core_reset;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic [7:0]        r_words_loaded;
  logic [7:0]        r_length;
  logic [7:0]        r_index;
  logic [7:0]        r_checksum;

  logic              w_accept;
  logic [7:0]        w_csum_sum;
  logic [7:0]        w_index_inc;
  logic              w_len_bad;
  logic              w_last_data;
  logic              w_csum_ok;
  logic              w_next_busy;

  assign w_accept    = in_valid && r_in_ready;
  assign w_csum_sum  = r_checksum + in_data;
  assign w_index_inc = r_index + 8'd1;
  assign w_len_bad   = (in_data == 8'd0) || ({1'b0, in_data} > MAX_LEN);
  assign w_last_data = (w_index_inc == r_length);
  assign w_csum_ok   = (w_csum_sum == 8'd0);

  // Next-state selection; start is only honoured outside an active frame.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_LEN;
      S_LEN:   if (w_accept) w_next_state = w_len_bad ? S_ERROR : S_DATA;
      S_DATA:  if (w_accept && w_last_data) w_next_state = S_CSUM;
      S_CSUM:  if (w_accept) w_next_state = w_csum_ok ? S_DONE : S_ERROR;
      S_DONE:  if (start) w_next_state = S_LEN;
      S_ERROR: if (start) w_next_state = S_LEN;
      default: w_next_state = S_IDLE;
    endcase
  end

  // The frame-active states are exactly the ones that accept bytes.
  assign w_next_busy = (w_next_state == S_LEN) || (w_next_state == S_DATA) ||
                       (w_next_state == S_CSUM);

  // FSM state, datapath registers and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_in_ready     <= 1'b0;
      r_imem_we      <= 1'b0;
      r_imem_addr    <= '0;
      r_imem_wdata   <= 8'd0;
      r_core_reset   <= 1'b1;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_words_loaded <= 8'd0;
      r_length       <= 8'd0;
      r_index        <= 8'd0;
      r_checksum     <= 8'd0;
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= w_next_busy;
      r_busy     <= w_next_busy;
      // Write strobe is a one-cycle pulse; it is re-armed only by a data accept.
      r_imem_we  <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            // Core goes back into reset on the very edge start is seen.
            r_core_reset   <= 1'b1;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
            r_words_loaded <= 8'd0;
            r_index        <= 8'd0;
            r_checksum     <= 8'd0;
          end
        end
        S_LEN: begin
          if (w_accept) begin
            // The length byte seeds the running checksum.
            r_checksum <= in_data;
            r_length   <= in_data;
            if (w_len_bad) r_error <= 1'b1;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_checksum     <= w_csum_sum;
            r_imem_we      <= 1'b1;
            r_imem_addr    <= ADDR_W'(r_index);
            r_imem_wdata   <= in_data;
            r_index        <= w_index_inc;
            r_words_loaded <= r_words_loaded + 8'd1;
          end
        end
        S_CSUM: begin
          if (w_accept) begin
            r_checksum <= w_csum_sum;
            if (w_csum_ok) begin
              r_done       <= 1'b1;
              r_core_reset <= 1'b0;
            end else begin
              r_error <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign imem_we      = r_imem_we;
  assign imem_addr    = r_imem_addr;
  assign imem_wdata   = r_imem_wdata;
  assign core_reset   = r_core_reset;
  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign words_loaded = r_words_loaded;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: frames are driven through the byte handshake and
// every memory write is checked against a queue built by a frame-level model.
module tb_imem_loader;
  localparam int ADDR_W    = 8;
  localparam int MAX_WORDS = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [7:0]        imem_wdata;
  logic              core_reset;
  logic              busy;
  logic              done;
  logic              error;
  logic [7:0]        words_loaded;
  logic [2:0]        dbg_state;

  int n_pass  = 0;
  int n_total = 0;

  logic [15:0] exp_q[$];   // expected {addr, data} writes in order
  logic [7:0]  data_q[$];  // instruction bytes of the frame being sent

  imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_reset(core_reset),
    .busy(busy), .done(done), .error(error), .words_loaded(words_loaded),
    .dbg_state(dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time budget, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

  // Scoreboard: every write strobe must match the next expected write.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: got addr=%h data=%h, required no write", imem_addr, imem_wdata);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== e)
          $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                   imem_addr, imem_wdata, e[15:8], e[7:0]);
        else n_pass++;
      end
    end
  end

  // Reference model: a frame is legal if 1 <= len <= MAX_WORDS; legal frames
  // write all data bytes to 0..len-1 and succeed if len+data+csum == 0 mod 256.
  task automatic model_frame(input logic [7:0] len, input logic [7:0] csum,
                             output bit exp_done, output int exp_words);
    int sum;
    if (len == 8'd0 || int'(len) > MAX_WORDS) begin
      exp_done = 1'b0;
      exp_words = 0;
      return;
    end
    sum = int'(len) + int'(csum);
    for (int i = 0; i < int'(len); i++) begin
      exp_q.push_back({8'(i), data_q[i]});
      sum += int'(data_q[i]);
    end
    exp_done = ((sum % 256) == 0);
    exp_words = int'(len);
  endtask

  function automatic logic [7:0] good_csum(input logic [7:0] len);
    int sum;
    sum = int'(len);
    foreach (data_q[i]) sum += int'(data_q[i]);
    return 8'((256 - (sum % 256)) % 256);
  endfunction

  task automatic fill_data(input int n);
    data_q.delete();
    for (int i = 0; i < n; i++) data_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // Driver tasks (entered and left on a falling edge)
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit mid_start);
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      start = (mid_start && g == 0);
      @(negedge clk);
    end
    start = 1'b0;
    in_valid = 1'b1;
    in_data = b;
    for (int t = 0; t < 20 && in_ready !== 1'b1; t++) @(negedge clk);
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL ready_timeout: got in_ready=%b, required 1 for byte %h", in_ready, b);
    else n_pass++;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] len, input logic [7:0] csum, input int max_gap,
                           input bit mid_start, output bit exp_done, output int exp_words);
    model_frame(len, csum, exp_done, exp_words);
    send_byte(len, 0, 1'b0);
    if (len != 8'd0 && int'(len) <= MAX_WORDS) begin
      for (int i = 0; i < int'(len); i++)
        send_byte(data_q[i], (max_gap > 0) ? int'($urandom_range(1, max_gap)) : 0, mid_start && i == 1);
      send_byte(csum, (max_gap > 0) ? int'($urandom_range(1, max_gap)) : 0, 1'b0);
    end
  endtask

  // Tests
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_total++; if ({in_ready, imem_we, imem_addr, imem_wdata} !== 18'd0)
      $display("FAIL reset_bus: got rdy=%b we=%b addr=%h wd=%h, required all 0", in_ready, imem_we, imem_addr, imem_wdata); else n_pass++;
    n_total++; if ({core_reset, busy, done, error} !== 4'b1000)
      $display("FAIL reset_status: got cr/busy/done/err=%b, required 1000", {core_reset, busy, done, error}); else n_pass++;
    n_total++; if (words_loaded !== 8'd0)
      $display("FAIL reset_words: got %0d, required 0", words_loaded); else n_pass++;
  endtask

  task automatic test_good_frame();
    bit ed; int ew;
    data_q = '{8'h10, 8'h2A, 8'h45};
    pulse_start();
    n_total++; if (busy !== 1'b1 || in_ready !== 1'b1)
      $display("FAIL good_busy: got busy=%b rdy=%b, required 1 1", busy, in_ready); else n_pass++;
    run_frame(8'h03, 8'h7E, 0, 1'b0, ed, ew);
    n_total++; if ({done, error, core_reset, busy, in_ready} !== 5'b10000)
      $display("FAIL good_status: got d/e/cr/b/r=%b, required 10000", {done, error, core_reset, busy, in_ready}); else n_pass++;
    n_total++; if (words_loaded !== 8'(ew) || ew != 3)
      $display("FAIL good_words: got %0d, required 3", words_loaded); else n_pass++;
    n_total++; if (exp_q.size() != 0)
      $display("FAIL good_writes: got %0d writes missing, required 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_bad_checksum();
    bit ed; int ew;
    data_q = '{8'h10, 8'h2A, 8'h45};
    pulse_start();
    run_frame(8'h03, 8'h7F, 0, 1'b0, ed, ew);
    n_total++; if ({done, error, core_reset} !== {ed, ~ed, ~ed} || ed)
      $display("FAIL badcs_status: got d/e/cr=%b, required 011", {done, error, core_reset}); else n_pass++;
    n_total++; if (exp_q.size() != 0 || words_loaded !== 8'd3)
      $display("FAIL badcs_writes: got missing=%0d words=%0d, required 0 and 3", exp_q.size(), words_loaded); else n_pass++;
  endtask

  task automatic test_length_checks();
    logic [7:0] lens[3];
    bit ed; int ew;
    lens = '{8'h00, 8'h21, 8'h20};
    foreach (lens[k]) begin
      fill_data((int'(lens[k]) <= MAX_WORDS) ? int'(lens[k]) : 0);
      pulse_start();
      run_frame(lens[k], good_csum(lens[k]), 0, 1'b0, ed, ew);
      n_total++; if ({done, error, core_reset, busy} !== {ed, ~ed, ~ed, 1'b0})
        $display("FAIL len_status[%h]: got d/e/cr/b=%b, required %b", lens[k], {done, error, core_reset, busy}, {ed, ~ed, ~ed, 1'b0}); else n_pass++;
      n_total++; if (words_loaded !== 8'(ew) || exp_q.size() != 0)
        $display("FAIL len_words[%h]: got words=%0d missing=%0d, required %0d and 0", lens[k], words_loaded, exp_q.size(), ew); else n_pass++;
    end
    n_total++; if (imem_addr !== 8'h1F)
      $display("FAIL len_last_addr: got %h, required 1f", imem_addr); else n_pass++;
  endtask

  task automatic test_stalls();
    bit ed; int ew;
    data_q = '{8'h10, 8'h2A, 8'h45};
    pulse_start();
    run_frame(8'h03, 8'h7E, 3, 1'b1, ed, ew);
    n_total++; if ({done, error, core_reset, busy} !== 4'b1000 || !ed)
      $display("FAIL stall_status: got d/e/cr/b=%b, required 1000", {done, error, core_reset, busy}); else n_pass++;
    n_total++; if (words_loaded !== 8'd3 || exp_q.size() != 0)
      $display("FAIL stall_words: got words=%0d missing=%0d, required 3 and 0", words_loaded, exp_q.size()); else n_pass++;
  endtask

  task automatic test_reset_mid_data();
    bit ed; int ew;
    data_q = '{8'h10, 8'h2A, 8'h45};
    pulse_start();
    exp_q.push_back({8'h00, 8'h10});
    send_byte(8'h03, 0, 1'b0);
    send_byte(8'h10, 0, 1'b0);
    in_valid = 1'b1; in_data = 8'h2A;
    @(posedge clk);
    #1 reset = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    n_total++; if ({in_ready, imem_we, imem_addr, imem_wdata} !== 18'd0)
      $display("FAIL midrst_bus: got rdy=%b we=%b addr=%h wd=%h, required all 0", in_ready, imem_we, imem_addr, imem_wdata); else n_pass++;
    n_total++; if ({core_reset, busy, done, error} !== 4'b1000 || words_loaded !== 8'd0)
      $display("FAIL midrst_status: got cr/b/d/e=%b words=%0d, required 1000 and 0", {core_reset, busy, done, error}, words_loaded); else n_pass++;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_total++; if (exp_q.size() != 0)
      $display("FAIL midrst_writes: got %0d writes missing, required 0", exp_q.size()); else n_pass++;
    pulse_start();
    run_frame(8'h03, 8'h7E, 0, 1'b0, ed, ew);
    n_total++; if ({done, error, core_reset} !== 3'b100 || exp_q.size() != 0)
      $display("FAIL midrst_reload: got d/e/cr=%b missing=%0d, required 100 and 0", {done, error, core_reset}, exp_q.size()); else n_pass++;
  endtask

  task automatic test_reload();
    bit ed; int ew;
    pulse_start();
    n_total++; if ({core_reset, done, busy} !== 3'b101)
      $display("FAIL reload_start: got cr/d/b=%b, required 101", {core_reset, done, busy}); else n_pass++;
    data_q = '{8'hA5};
    run_frame(8'h01, 8'h5A, 0, 1'b0, ed, ew);
    n_total++; if ({done, error, core_reset} !== 3'b100 || words_loaded !== 8'd1 || exp_q.size() != 0)
      $display("FAIL reload_done: got d/e/cr=%b words=%0d missing=%0d, required 100 1 0", {done, error, core_reset}, words_loaded, exp_q.size()); else n_pass++;
  endtask

  task automatic test_random_frames();
    bit ed; int ew;
    logic [7:0] len, cs;
    for (int it = 0; it < 12; it++) begin
      case ($urandom_range(0, 5))
        0:       len = 8'($urandom_range(MAX_WORDS + 1, 255));
        1:       len = 8'd0;
        default: len = 8'($urandom_range(1, MAX_WORDS));
      endcase
      fill_data((len != 8'd0 && int'(len) <= MAX_WORDS) ? int'(len) : 0);
      cs = good_csum(len);
      if ($urandom_range(0, 1) == 1) cs = cs + 8'($urandom_range(1, 255));
      pulse_start();
      run_frame(len, cs, int'($urandom_range(0, 2)), 1'b0, ed, ew);
      n_total++; if ({done, error, core_reset, busy, in_ready} !== {ed, ~ed, ~ed, 2'b00})
        $display("FAIL rand_status[%0d]: len=%h got d/e/cr/b/r=%b, required %b", it, len, {done, error, core_reset, busy, in_ready}, {ed, ~ed, ~ed, 2'b00}); else n_pass++;
      n_total++; if (words_loaded !== 8'(ew) || exp_q.size() != 0)
        $display("FAIL rand_words[%0d]: got words=%0d missing=%0d, required %0d and 0", it, words_loaded, exp_q.size(), ew); else n_pass++;
    end
  endtask

  // Sequence and report
  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_length_checks();
    test_stalls();
    test_reset_mid_data();
    test_reload();
    test_random_frames();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
